ngp_writeback: RTL and testbench

- Commit stage directly downstream of the core's execute/handler stage.
- Consumes the ALU result, the 3-bit destination field and the jump flag, and owns the architectural A, D and PC registers.
- Issues *A (data-memory) writes over a valid/ready handshake, back-pressuring execute while a write is outstanding.
- Also handles immediate-load instructions (instruction bit 15 = 0) and keeps a retired-instruction counter.

---
 rtl/ngp_writeback_if.sv | 32 +++
 rtl/ngp_writeback.sv | 101 ++++++++++
 tb/tb_ngp_writeback.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ngp_writeback_if.sv
// Bundle between execute, the writeback/commit stage and the data-memory write port.
// The master side drives the instruction and memory-ready signals; the slave side is the commit stage.
interface ngp_writeback_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             is_alu;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] result;
    logic [2:0]       dst;
    logic             jmp;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] pc;
    logic             mem_wr_valid;
    logic             mem_wr_ready;
    logic [WIDTH-1:0] mem_wr_addr;
    logic [WIDTH-1:0] mem_wr_data;
    logic [CNT_W-1:0] retired;

    modport master (
        output in_valid, is_alu, imm, result, dst, jmp, mem_wr_ready,
        input  in_ready, a_reg, d_reg, pc, mem_wr_valid, mem_wr_addr, mem_wr_data, retired
    );

    modport slave (
        input  in_valid, is_alu, imm, result, dst, jmp, mem_wr_ready,
        output in_ready, a_reg, d_reg, pc, mem_wr_valid, mem_wr_addr, mem_wr_data, retired
    );
endinterface

// File: rtl/ngp_writeback.sv
// Commit stage: owns architectural A, D and PC, issues *A writes over valid/ready and
// stalls execute until each write is accepted. Also counts retired instructions.
module ngp_writeback #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      CNT_W    = 32
) (
    input logic            clk,
    input logic            rst_n,
    ngp_writeback_if.slave wb
);

    localparam logic [WIDTH-1:0] One    = WIDTH'(1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic accept;
    assign accept = wb.in_valid && (state_q == StRun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (accept && wb.is_alu && wb.dst[0]) state_d = StMemWait;
            StMemWait: if (wb.mem_wr_ready) state_d = StRun;
        endcase
    end

    always_comb begin
        wb.in_ready     = (state_q == StRun);
        wb.mem_wr_valid = (state_q == StMemWait);
    end

    // All updates read pre-edge register values; the write address is A before this instruction.
    always_comb begin
        a_d    = a_q;
        d_d    = d_q;
        pc_d   = pc_q;
        addr_d = addr_q;
        data_d = data_q;
        ret_d  = ret_q;
        if (accept) begin
            ret_d = ret_q + CntOne;
            if (!wb.is_alu) begin
                a_d  = wb.imm;
                pc_d = pc_q + One;
            end else begin
                if (wb.dst[2]) a_d = wb.result;
                if (wb.dst[1]) d_d = wb.result;
                if (wb.dst[0]) begin
                    addr_d = a_q;
                    data_d = wb.result;
                end
                pc_d = wb.jmp ? a_q : (pc_q + One);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            d_q    <= '0;
            pc_q   <= RESET_PC;
            addr_q <= '0;
            data_q <= '0;
            ret_q  <= '0;
        end else begin
            a_q    <= a_d;
            d_q    <= d_d;
            pc_q   <= pc_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ret_q  <= ret_d;
        end
    end

    assign wb.a_reg       = a_q;
    assign wb.d_reg       = d_q;
    assign wb.pc          = pc_q;
    assign wb.mem_wr_addr = addr_q;
    assign wb.mem_wr_data = data_q;
    assign wb.retired     = ret_q;

endmodule

// File: tb/tb_ngp_writeback.sv
// Bench for ngp_writeback: directed scenarios then random traffic, all checked against a
// transaction-level model of the commit rules.
module tb_ngp_writeback;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst_n;

    ngp_writeback_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    ngp_writeback #(
        .WIDTH   (W),
        .RESET_PC(16'h0000),
        .CNT_W   (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [15:0] m_a, m_d, m_pc, m_waddr, m_wdata;
    int          m_ret;
    bit          m_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_d = '0; m_pc = 16'h0000; m_waddr = '0; m_wdata = '0;
        m_ret = 0; m_busy = 1'b0;
    endtask

    task automatic check_all();
        check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
        check("wr_valid", 32'(bus.mem_wr_valid), 32'(m_busy));
        check("a_reg", 32'(bus.a_reg), 32'(m_a));
        check("d_reg", 32'(bus.d_reg), 32'(m_d));
        check("pc", 32'(bus.pc), 32'(m_pc));
        check("retired", 32'(bus.retired), 32'(m_ret % 256));
        check("wr_addr", 32'(bus.mem_wr_addr), 32'(m_waddr));
        check("wr_data", 32'(bus.mem_wr_data), 32'(m_wdata));
    endtask

    // Called just after a falling edge: apply inputs, advance the model over the next
    // rising edge, then check at the following falling edge.
    task automatic cycle(input bit v, input bit alu, input logic [15:0] imm,
                         input logic [15:0] res, input logic [2:0] dst, input bit jmp,
                         input bit wr_rdy);
        logic [15:0] old_a;
        bus.in_valid = v; bus.is_alu = alu; bus.imm = imm; bus.result = res;
        bus.dst = dst; bus.jmp = jmp; bus.mem_wr_ready = wr_rdy;
        if (!m_busy) begin
            if (v) begin
                old_a = m_a;
                m_ret = (m_ret + 1) % 256;
                if (!alu) begin
                    m_a  = imm;
                    m_pc = m_pc + 16'd1;
                end else begin
                    if (dst[2]) m_a = res;
                    if (dst[1]) m_d = res;
                    if (dst[0]) begin
                        m_waddr = old_a; m_wdata = res; m_busy = 1'b1;
                    end
                    m_pc = jmp ? old_a : m_pc + 16'd1;
                end
            end
        end else if (wr_rdy) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic imm_load(input logic [15:0] v);
        cycle(1'b1, 1'b0, v, 16'h0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.is_alu = 1'b0; bus.imm = '0; bus.result = '0;
        bus.dst = '0; bus.jmp = 1'b0; bus.mem_wr_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Immediate load ignores dst/jmp
        cycle(1'b1, 1'b0, 16'h1234, 16'hBEEF, 3'b111, 1'b1, 1'b0);
        check("imm_a", 32'(bus.a_reg), 32'h1234);
        check("imm_pc", 32'(bus.pc), 32'h0001);

        // Reach pc=5, A=0x40, then A+D+jump
        imm_load(16'h0011); imm_load(16'h0022); imm_load(16'h0033); imm_load(16'h0040);
        cycle(1'b1, 1'b1, 16'h0, 16'h00AA, 3'b110, 1'b1, 1'b0);
        check("adj_a", 32'(bus.a_reg), 32'h00AA);
        check("adj_d", 32'(bus.d_reg), 32'h00AA);
        check("adj_pc", 32'(bus.pc), 32'h0040);

        // Memory write with 3-cycle stall; in_valid pulses during the wait are dropped
        imm_load(16'h0100);
        cycle(1'b1, 1'b1, 16'h0, 16'h5555, 3'b101, 1'b0, 1'b0);
        check("mw_a", 32'(bus.a_reg), 32'h5555);
        for (int i = 0; i < 3; i++) begin
            check("mw_addr", 32'(bus.mem_wr_addr), 32'h0100);
            check("mw_data", 32'(bus.mem_wr_data), 32'h5555);
            cycle(i[0] == 1'b0, 1'b1, 16'h0, 16'h7777, 3'b111, 1'b1, 1'b0);
        end
        check("mw_valid4", 32'(bus.mem_wr_valid), 32'h1);
        cycle(1'b1, 1'b1, 16'h0, 16'h7777, 3'b111, 1'b1, 1'b1);
        check("mw_ready_back", 32'(bus.in_ready), 32'h1);

        // PC wrap: jump to 0xFFFF then a plain ALU step
        imm_load(16'hFFFF);
        cycle(1'b1, 1'b1, 16'h0, 16'h0, 3'b000, 1'b1, 1'b0);
        check("pc_ffff", 32'(bus.pc), 32'hFFFF);
        cycle(1'b1, 1'b1, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0);
        check("pc_wrap", 32'(bus.pc), 32'h0000);

        // Retired counter wrap
        while (m_ret != 255) imm_load(16'($urandom));
        imm_load(16'h0003);
        check("ret_wrap", 32'(bus.retired), 32'h0);

        // Reset while a write is pending
        cycle(1'b1, 1'b1, 16'h0, 16'h1111, 3'b001, 1'b0, 1'b0);
        check("rst_pre_valid", 32'(bus.mem_wr_valid), 32'h1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_async_valid", 32'(bus.mem_wr_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            cycle(($urandom % 10) < 7, $urandom % 2 == 1, 16'($urandom), 16'($urandom),
                  3'($urandom), ($urandom % 10) < 3, $urandom % 2 == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
